// File: rtl/chr_font_loader.sv
`default_nettype none
// ============================================================================
// Module   : chr_font_loader
// Purpose  : Writer side of the text-mode font RAM. Takes a start command with
//            a character code, then ROWS glyph bytes over valid/ready, and
//            writes each byte to ((chr_val - FIRST_CHR) << 4) + row.
// Option   : CHR_FONT_LOADER_TIMEOUT_EN enables the inter-byte idle timeout.
// Revision : 1.0  initial release
// ============================================================================
module chr_font_loader #(
  parameter int FIRST_CHR   = 32,
  parameter int NUM_CHR     = 96,
  parameter int ROWS        = 16,
  parameter int ADDR_W      = 11
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        chr_val,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [3:0]          row_cnt_q,   row_cnt_d;
  logic [ADDR_W-1:0]   base_q,      base_d;
  logic                ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic                err_q,       err_d;

`ifdef CHR_FONT_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0]   idle_cnt_q,  idle_cnt_d;
`endif

  logic       hs;
  logic       in_range;
  logic [7:0] chr_off;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    base_d      = base_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    err_d       = 1'b0;
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif

    byte_ready = (state_q == S_LOAD);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    hs         = byte_valid && (state_q == S_LOAD);
    chr_off    = chr_val - 8'(FIRST_CHR);
    in_range   = (int'(chr_val) >= FIRST_CHR) &&
                 (int'(chr_val) <  FIRST_CHR + NUM_CHR);

    case (state_q)
      S_IDLE: begin
        // A byte offered in the same cycle as start is left for LOAD.
        if (start) begin
          if (in_range) begin
            base_d    = ADDR_W'({chr_off, 4'b0000});
            row_cnt_d = 4'd0;
            state_d   = S_LOAD;
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (hs) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = base_q + ADDR_W'(row_cnt_q);
          ram_wdata_d = byte_data;
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
          idle_cnt_d  = '0;
`endif
          if (row_cnt_q == 4'(ROWS - 1)) begin
            state_d = S_DONE;
          end else begin
            row_cnt_d = row_cnt_q + 4'd1;
          end
        end
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
        else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
`endif
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= 4'd0;
      base_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
      err_q       <= 1'b0;
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      base_q      <= base_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      err_q       <= err_d;
`ifdef CHR_FONT_LOADER_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
`endif
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_chr_font_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_chr_font_loader
// Purpose  : Self-checking bench for chr_font_loader; each glyph load is
//            predicted from the character code and the row bytes offered.
// Revision : 1.0  initial release
// ============================================================================
module tb_chr_font_loader;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        chr_val = 8'd0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              busy;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;

  chr_font_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .chr_val    (chr_val),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(ram_we),    32'd0);
    check({tag, "_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
  endtask

  // One glyph load. seq: rows are 0..15; gap_pct: chance of an idle cycle
  // between bytes; poke: drive a stray start during LOAD/DONE;
  // abort_after: assert rst right after that many bytes (0 = never).
  task automatic do_load(input logic [7:0] c, input bit seq, input int gap_pct,
                         input bit poke, input int abort_after);
    logic [7:0] rows [16];
    int base;
    int k;
    int iter;
    bit hs;
    base = (int'(c) - 32) * 16;
    for (int i = 0; i < 16; i++) rows[i] = seq ? 8'(i) : 8'($urandom);

    start = 1'b1; chr_val = c; byte_valid = 1'b1; byte_data = 8'hEE;
    tick();
    check("start_busy",  32'(busy),       32'd1);
    check("start_ready", 32'(byte_ready), 32'd1);
    check("start_nowe",  32'(ram_we),     32'd0);
    start = 1'b0;

    k = 0;
    iter = 0;
    while (k < 16) begin
      iter++;
      if (iter > 400) begin
        check("load_iter_bound", 32'(k), 32'd16);
        break;
      end
      if (k > 0 && $urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0; byte_data = 8'($urandom);
      end else begin
        byte_valid = 1'b1; byte_data = rows[k];
      end
      if (poke) begin
        start = 1'($urandom_range(1)); chr_val = 8'h50;
      end
      hs = byte_valid;
      tick();
      check("we", 32'(ram_we), 32'(hs));
      if (hs) begin
        check("addr",  32'(ram_addr),  32'(base + k));
        check("wdata", 32'(ram_wdata), 32'(rows[k]));
        k++;
      end
      check("err_load", 32'(err), 32'd0);
      if (abort_after != 0 && k == abort_after) begin
        rst = 1'b1; byte_valid = 1'b1; start = 1'b0;
        tick();
        check_all_zero("abort");
        rst = 1'b0; byte_valid = 1'b0;
        tick();
        check_all_zero("abort_after");
        return;
      end
      if (k < 16) begin
        check("busy_load",  32'(busy),       32'd1);
        check("ready_load", 32'(byte_ready), 32'd1);
        check("done_early", 32'(done),       32'd0);
      end else begin
        check("done_pulse", 32'(done),       32'd1);
        check("busy_done",  32'(busy),       32'd1);
        check("ready_done", 32'(byte_ready), 32'd0);
      end
    end

    byte_valid = 1'b0;
    start = poke;
    chr_val = 8'h50;
    tick();
    start = 1'b0;
    check("post_done", 32'(done),   32'd0);
    check("post_busy", 32'(busy),   32'd0);
    check("post_we",   32'(ram_we), 32'd0);
    check("post_err",  32'(err),    32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic bad_chr(input logic [7:0] c);
    start = 1'b1; chr_val = c;
    tick();
    start = 1'b0;
    check("bad_err",  32'(err),    32'd1);
    check("bad_busy", 32'(busy),   32'd0);
    check("bad_we",   32'(ram_we), 32'd0);
    tick();
    check("bad_err_clr", 32'(err),  32'd0);
    check("bad_busy2",   32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Bytes offered while idle are neither accepted nor written.
    byte_valid = 1'b1; byte_data = 8'h5A;
    tick();
    check("idle_ready", 32'(byte_ready), 32'd0);
    tick();
    check("idle_we", 32'(ram_we), 32'd0);
    byte_valid = 1'b0;

    do_load(8'h41, 1'b1, 0, 1'b0, 0);
    do_load(8'h20, 1'b0, 50, 1'b0, 0);
    bad_chr(8'h1F);
    bad_chr(8'h80);
    do_load(8'h7E, 1'b0, 0, 1'b0, 5);
    do_load(8'h7E, 1'b0, 0, 1'b0, 0);
    do_load(8'h41, 1'b0, 20, 1'b1, 0);
    do_load(8'h7F, 1'b0, 30, 1'b0, 0);

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(3))
        0: bad_chr(8'($urandom_range(31)));
        1: bad_chr(8'($urandom_range(255, 128)));
        default: do_load(8'($urandom_range(127, 32)), 1'b0,
                         int'($urandom_range(60)), 1'($urandom_range(1)), 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
